// File: rtl/video_tpg_timing.sv
// Video timing generator and test-pattern source (colour bars, solid, gray ramp, checkerboard).
// Latency: every output registered, 1 cycle after the (h_cnt, v_cnt) position it describes.
// Backpressure: none; pix_en low freezes counters and outputs (frame_start forced low).
// Optional macro VIDEO_TPG_SCROLL_EN adds frame_cnt and scrolls the ramp/checkerboard per frame.
module video_tpg_timing #(
  parameter int H_SYNC   = 44,
  parameter int H_BACK   = 148,
  parameter int H_ACTIVE = 1920,
  parameter int H_FRONT  = 88,
  parameter int V_SYNC   = 5,
  parameter int V_BACK   = 36,
  parameter int V_ACTIVE = 1080,
  parameter int V_FRONT  = 4,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1,
  parameter int CHK_LOG2 = 5,
  parameter int CW       = 13
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          pix_en,
  input  logic [1:0]    mode,
  input  logic [23:0]   solid_rgb,
  output logic [23:0]   rgb,
  output logic          de,
  output logic          hs,
  output logic          vs,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          frame_start
`ifdef VIDEO_TPG_SCROLL_EN
  ,
  output logic [15:0]   frame_cnt
`endif
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

  localparam logic [CW-1:0] H_MAX   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_MAX   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_SYNC_C = CW'(H_SYNC);
  localparam logic [CW-1:0] V_SYNC_C = CW'(V_SYNC);
  localparam logic [CW-1:0] H_ACT0  = CW'(H_SYNC + H_BACK);
  localparam logic [CW-1:0] H_ACT1  = CW'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [CW-1:0] V_ACT0  = CW'(V_SYNC + V_BACK);
  localparam logic [CW-1:0] V_ACT1  = CW'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [CW-1:0] BW_M1   = CW'(H_ACTIVE / 8 - 1);
  localparam logic          HS_ON   = (HS_POL != 0);
  localparam logic          VS_ON   = (VS_POL != 0);

  logic [CW-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [CW-1:0] bar_pix_q, bar_pix_d;
  logic [2:0]    bar_idx_q, bar_idx_d;
  logic [1:0]    mode_r_q, mode_r_d;
  logic [23:0]   rgb_q, rgb_d;
  logic          de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
  logic [CW-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;

  logic          h_act, v_act, act, fs_c, frame_wrap;
  logic [CW-1:0] x_c, y_c, chk_x;
  logic [7:0]    ramp;
  logic [23:0]   bar_rgb, rgb_c;
  logic [15:0]   fcnt;

`ifdef VIDEO_TPG_SCROLL_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // Frame counter steps at the frame boundary so it reads N for the whole of frame N
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_wrap) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  assign fcnt      = frame_cnt_q;
  assign frame_cnt = frame_cnt_q;
`else
  assign fcnt = 16'd0;
`endif

  // Raster counters: h wraps each line, v steps on h wrap and wraps at the end of the frame
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_en) begin
      if (h_cnt_q == H_MAX) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_MAX) ? '0 : v_cnt_q + CW'(1);
      end else begin
        h_cnt_d = h_cnt_q + CW'(1);
      end
    end
  end

  // Position decode for the current raster point
  always_comb begin
    h_act      = (h_cnt_q >= H_ACT0) && (h_cnt_q < H_ACT1);
    v_act      = (v_cnt_q >= V_ACT0) && (v_cnt_q < V_ACT1);
    act        = h_act && v_act;
    x_c        = act ? h_cnt_q - H_ACT0 : '0;
    y_c        = act ? v_cnt_q - V_ACT0 : '0;
    fs_c       = (h_cnt_q == '0) && (v_cnt_q == '0);
    frame_wrap = pix_en && (h_cnt_q == H_MAX) && (v_cnt_q == V_MAX);
    mode_r_d   = (pix_en && fs_c) ? mode : mode_r_q;
  end

  // Bar position counters: cleared outside the active span, index saturates at the last bar
  always_comb begin
    bar_pix_d = bar_pix_q;
    bar_idx_d = bar_idx_q;
    if (pix_en) begin
      if (!h_act) begin
        bar_pix_d = '0;
        bar_idx_d = '0;
      end else if (bar_pix_q == BW_M1) begin
        bar_pix_d = '0;
        if (bar_idx_q != 3'd7) bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_pix_d = bar_pix_q + CW'(1);
      end
    end
  end

  // Pattern select; mode_r only changes at a frame start so a frame never mixes patterns
  always_comb begin
    case (bar_idx_q)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
    ramp  = x_c[7:0] + fcnt[7:0];
    chk_x = x_c + CW'(fcnt);
    rgb_c = '0;
    if (act) begin
      case (mode_r_q)
        2'd0:    rgb_c = bar_rgb;
        2'd1:    rgb_c = solid_rgb;
        2'd2:    rgb_c = {ramp, ramp, ramp};
        default: rgb_c = (chk_x[CHK_LOG2] ^ y_c[CHK_LOG2]) ? 24'h000000 : 24'hFFFFFF;
      endcase
    end
  end

  // Output stage: load decoded values when enabled, otherwise hold (frame_start drops)
  always_comb begin
    rgb_d   = pix_en ? rgb_c : rgb_q;
    de_d    = pix_en ? act : de_q;
    hs_d    = pix_en ? ((h_cnt_q < H_SYNC_C) ? HS_ON : ~HS_ON) : hs_q;
    vs_d    = pix_en ? ((v_cnt_q < V_SYNC_C) ? VS_ON : ~VS_ON) : vs_q;
    pix_x_d = pix_en ? x_c : pix_x_q;
    pix_y_d = pix_en ? y_c : pix_y_q;
    fs_d    = pix_en && fs_c;
  end

  // State and output registers
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      h_cnt_q   <= '0;
      v_cnt_q   <= '0;
      bar_pix_q <= '0;
      bar_idx_q <= '0;
      mode_r_q  <= '0;
      rgb_q     <= '0;
      de_q      <= 1'b0;
      hs_q      <= ~HS_ON;
      vs_q      <= ~VS_ON;
      pix_x_q   <= '0;
      pix_y_q   <= '0;
      fs_q      <= 1'b0;
`ifdef VIDEO_TPG_SCROLL_EN
      frame_cnt_q <= '0;
`endif
    end else begin
      h_cnt_q   <= h_cnt_d;
      v_cnt_q   <= v_cnt_d;
      bar_pix_q <= bar_pix_d;
      bar_idx_q <= bar_idx_d;
      mode_r_q  <= mode_r_d;
      rgb_q     <= rgb_d;
      de_q      <= de_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      pix_x_q   <= pix_x_d;
      pix_y_q   <= pix_y_d;
      fs_q      <= fs_d;
`ifdef VIDEO_TPG_SCROLL_EN
      frame_cnt_q <= frame_cnt_d;
`endif
    end
  end

  assign rgb         = rgb_q;
  assign de          = de_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign frame_start = fs_q;

endmodule

// File: doc/video_tpg_timing.md
Name: video_tpg_timing

Overview:
- Parametrised video timing generator and test-pattern source; next generation of the fixed 1920x1080 colour-bar generator.
- Timing values, sync polarity and pattern are configurable. A clock-enable is added, and pixel x/y coordinates are exported for downstream overlay logic.
- Sits at the head of the HDMI/TMDS output path and drives RGB, DE, HS and VS into the encoder.

Parameters:
- H_SYNC, 44, horizontal sync width in pixels
- H_BACK, 148, horizontal back porch
- H_ACTIVE, 1920, active pixels per line (must be >= 8)
- H_FRONT, 88, horizontal front porch
- V_SYNC, 5, vertical sync width in lines
- V_BACK, 36, vertical back porch
- V_ACTIVE, 1080, active lines per frame
- V_FRONT, 4, vertical front porch
- HS_POL, 1, asserted level of hs (1 = active-high)
- VS_POL, 1, asserted level of vs
- CHK_LOG2, 5, checkerboard cell size is 2^CHK_LOG2 pixels
- CW, 13, width of the h/v counters and the x/y ports

Ports:
- sys_clk  in  1  pixel clock
- sys_rst  in  1  asynchronous reset, active-high
- pix_en  in  1  clock enable; counters and outputs advance only when high
- mode  in  2  pattern select: 0 = colour bars, 1 = solid, 2 = gray ramp, 3 = checkerboard
- solid_rgb  in  24  colour used in mode 1, packed {R,G,B}
- rgb  out  24  pixel data {R[23:16],G[15:8],B[7:0]}
- de  out  1  data enable
- hs  out  1  horizontal sync, polarity set by HS_POL
- vs  out  1  vertical sync, polarity set by VS_POL
- pix_x  out  CW  active column, 0..H_ACTIVE-1 when de=1, else 0
- pix_y  out  CW  active line, 0..V_ACTIVE-1 when de=1, else 0
- frame_start  out  1  one-cycle pulse coincident with the first sync cycle of each frame

Behaviour:
- Derived totals: H_TOTAL = H_SYNC+H_BACK+H_ACTIVE+H_FRONT; V_TOTAL is the vertical equivalent.
- Line and frame order: sync, back porch, active, front porch.
- h_cnt runs 0..H_TOTAL-1 and wraps to 0. v_cnt increments when h_cnt wraps, and wraps to 0 when both counters are at their maximum in the same cycle.
- Every output is registered with exactly 1 cycle latency from (h_cnt, v_cnt). hs, vs, de, rgb, pix_x and pix_y are mutually aligned.
- hs = HS_POL when h_cnt < H_SYNC, else ~HS_POL. vs is the same rule using v_cnt, V_SYNC and VS_POL.
- de = 1 when h_cnt is in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE) and v_cnt is in the vertical equivalent window.
- frame_start = 1 for one cycle when h_cnt==0 and v_cnt==0.
- rgb = 0 whenever de = 0.
- pix_en low: counters hold and every output holds its value; frame_start is held low, so the pulse is not repeated.
- mode is latched into mode_r only in the frame_start cycle, so patterns never change mid-frame. mode_r resets to 0.
- Mode 0, colour bars:
  - 8 bars in order white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - Bar width BW = H_ACTIVE/8. Bar index comes from a bar pixel counter and a 3-bit bar counter that clear at the start of each active line; no divider is used.
  - The index saturates at 7, so bar 7 absorbs any remainder pixels.
- Mode 1, solid: rgb = solid_rgb, sampled every cycle (not latched per frame).
- Mode 2, gray ramp: R=G=B=pix_x[7:0]; the ramp repeats every 256 pixels.
- Mode 3, checkerboard: white when pix_x[CHK_LOG2] ^ pix_y[CHK_LOG2] = 0, else black.
- Reset values: counters 0, mode_r 0, rgb 0, de 0, hs ~HS_POL, vs ~VS_POL, pix_x 0, pix_y 0, frame_start 0.
- Reset deasserted: the first enabled cycle produces frame_start=1 one cycle later.
- Reset mid-frame: immediate return to the reset state; the next frame restarts from h_cnt=0, v_cnt=0.

Optional Feature:
- Macro: VIDEO_TPG_SCROLL_EN.
- Defined:
  - Adds output port frame_cnt [15:0], which increments on each frame_start, wraps at FFFF and resets to 0.
  - Mode 3 uses (pix_x + frame_cnt) in place of pix_x, so the checkerboard scrolls 1 pixel per frame.
  - Mode 2 uses pix_x[7:0] + frame_cnt[7:0].
- Undefined: no frame_cnt port, and all patterns are static.

Test Plan:
- Small timing (H 2/3/16/1, V 1/2/4/1, pix_en=1) -> hs period 22 cycles, high for 2 cycles; de high for 16 cycles per line on 4 lines; vs high for 1 line (22 cycles); frame is 176 cycles; frame_start period 176.
- Mode 0, H_ACTIVE=19 -> rgb per 2-pixel bar FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF; black for the last 5 pixels; pix_x counts 0..18.
- mode changed from 0 to 3 mid-frame -> rest of the frame stays colour bars; next frame checkerboard with CHK_LOG2=1 giving FFFFFF,FFFFFF,000000,000000 on line 0.
- pix_en toggled 1,0,0,1 during active -> outputs frozen for 2 cycles; pix_x resumes at +1 with no skipped or duplicated pixel.
- sys_rst pulsed mid-active -> same cycle de=0, rgb=0, hs=~HS_POL; after release, frame_start asserts 1 cycle later; HS_POL=0 run gives hs low only during sync.
- With VIDEO_TPG_SCROLL_EN, mode 3, CHK_LOG2=1 -> frame 1 line 0 starts FFFFFF,000000,000000,FFFFFF (1-pixel shift); frame_cnt=1.
